// File: rtl/dot_product_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dot_product_sequencer
// Brief    : Upstream controller for an 8x8->16 multiply-accumulate unit.
//            Streams (x, w) pairs into the MAC, clears it per vector, and
//            captures the finished accumulator on a valid/ready result port.
// Revision : 1.0 - initial release
// ============================================================================
module dot_product_sequencer #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 16,
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_w,
  input  logic              in_last,
  output logic [DATA_W-1:0] mac_x,
  output logic [DATA_W-1:0] mac_w,
  output logic              mac_enable,
  output logic              mac_clear,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_trunc,
  output logic              busy
);

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // The counter compare is done one bit wider so counter+1 never wraps.
  localparam logic [CNT_W:0] c_max_len = (CNT_W + 1)'(MAX_LEN);
  localparam logic [CNT_W:0] c_one     = (CNT_W + 1)'(1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic             r_trunc;
  logic             w_accept;
  logic             w_end;
  logic [CNT_W:0]   w_count_inc;

  assign w_accept    = (r_state == STREAM) && in_valid;
  assign w_count_inc = {1'b0, r_count} + c_one;
  // A vector ends on its marked last element or when it hits the length cap.
  assign w_end       = w_accept && (in_last || (w_count_inc == c_max_len));
  assign busy        = (r_state != CLEAR);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= CLEAR;
    else       r_state <= w_next;
  end

  // Next-state decode and the combinational MAC/input-handshake drive.
  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    mac_x      = '0;
    mac_w      = '0;
    mac_enable = 1'b0;
    mac_clear  = 1'b0;
    case (r_state)
      CLEAR: begin
        mac_clear = 1'b1;
        w_next    = STREAM;
      end
      STREAM: begin
        in_ready   = 1'b1;
        mac_enable = in_valid;
        mac_x      = in_x;
        mac_w      = in_w;
        if (w_end) w_next = DRAIN;
      end
      DRAIN: begin
        w_next = HOLD;
      end
      HOLD: begin
        if (res_ready) w_next = CLEAR;
      end
      default: begin
        w_next = CLEAR;
      end
    endcase
  end

  // Element counter, truncation flag and the result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_trunc   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_count <= '0;
      res_trunc <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_count <= '0;
        end
        STREAM: begin
          if (w_accept) r_count <= w_count_inc[CNT_W-1:0];
          if (w_end)    r_trunc <= ~in_last;
        end
        DRAIN: begin
          // The MAC has absorbed the final product by this cycle.
          res_data  <= mac_acc;
          res_count <= r_count;
          res_trunc <= r_trunc;
          res_valid <= 1'b1;
        end
        HOLD: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: begin
          r_count <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dot_product_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_product_sequencer
// Brief    : Directed bench for dot_product_sequencer with a behavioural MAC.
//            MAX_LEN is set to 4 so the forced-termination path is reachable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dot_product_sequencer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [7:0]  in_w;
  logic        in_last;
  logic [7:0]  mac_x;
  logic [7:0]  mac_w;
  logic        mac_enable;
  logic        mac_clear;
  logic [15:0] mac_acc;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [6:0]  res_count;
  logic        res_trunc;
  logic        busy;

  int vectors;
  int miscompares;

  int xs [0:5] = '{10, 99, 99, 20, 99, 30};
  bit vs [0:5] = '{1, 0, 0, 1, 0, 1};

  dot_product_sequencer #(
    .DATA_W(8), .ACC_W(16), .MAX_LEN(4), .CNT_W(7)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_w(in_w), .in_last(in_last),
    .mac_x(mac_x), .mac_w(mac_w), .mac_enable(mac_enable),
    .mac_clear(mac_clear), .mac_acc(mac_acc),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_count(res_count), .res_trunc(res_trunc),
    .busy(busy)
  );

  // Clock generation, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC: clear wins, otherwise accumulate on enable.
  always_ff @(posedge clk) begin
    if (mac_clear)       mac_acc <= 16'd0;
    else if (mac_enable) mac_acc <= mac_acc + ({8'd0, mac_x} * {8'd0, mac_w});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one element and hold it until it is accepted (bounded wait).
  task automatic send(input logic [7:0] x, input logic [7:0] w, input logic last);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_w     = w;
    in_last  = last;
    #1;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $error("FAIL send_timeout observed=%0d expected=%0d", in_ready, 1);
    end else begin
      check("mac_enable_on_accept", mac_enable, 1);
      check("mac_x_on_accept", mac_x, x);
      check("mac_w_on_accept", mac_w, w);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Watchdog so the run always ends even if the design wedges.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_x        = 8'd0;
    in_w        = 8'd0;
    in_last     = 1'b0;
    res_ready   = 1'b1;
    tick();
    tick();

    // Reset state.
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_count", res_count, 0);
    check("rst_res_trunc", res_trunc, 0);
    check("rst_busy", busy, 0);
    check("rst_mac_clear", mac_clear, 1);
    check("rst_in_ready", in_ready, 0);
    reset = 1'b0;

    // Basic vector {1,2,3,4} . {5,6,7,8} = 70, with latency checks.
    send(8'd1, 8'd5, 1'b0);
    send(8'd2, 8'd6, 1'b0);
    send(8'd3, 8'd7, 1'b0);
    send(8'd4, 8'd8, 1'b1);
    check("drain_res_valid", res_valid, 0);
    check("drain_in_ready", in_ready, 0);
    check("drain_busy", busy, 1);
    tick();
    check("v1_res_valid", res_valid, 1);
    check("v1_res_data", res_data, 70);
    check("v1_res_count", res_count, 4);
    check("v1_res_trunc", res_trunc, 0);
    tick();
    check("v1_valid_one_cycle", res_valid, 0);
    check("v1_back_to_clear", mac_clear, 1);

    // Length-1 vector at full-scale operands.
    send(8'd255, 8'd255, 1'b1);
    tick();
    check("len1_res_data", res_data, 65025);
    check("len1_res_count", res_count, 1);
    check("len1_res_trunc", res_trunc, 0);

    // Next vector must start from a cleared accumulator.
    send(8'd2, 8'd3, 1'b1);
    tick();
    check("after_len1_res_data", res_data, 6);
    check("after_len1_res_count", res_count, 1);

    // Forced termination at MAX_LEN=4, remainder forms the next vector.
    send(8'd1, 8'd1, 1'b0);
    send(8'd1, 8'd1, 1'b0);
    send(8'd1, 8'd1, 1'b0);
    send(8'd1, 8'd1, 1'b0);
    tick();
    check("trunc_res_valid", res_valid, 1);
    check("trunc_res_data", res_data, 4);
    check("trunc_res_count", res_count, 4);
    check("trunc_res_trunc", res_trunc, 1);
    send(8'd1, 8'd1, 1'b0);
    send(8'd1, 8'd1, 1'b1);
    tick();
    check("rest_res_data", res_data, 2);
    check("rest_res_count", res_count, 2);
    check("rest_res_trunc", res_trunc, 0);

    // Backpressure: result held while res_ready stays low.
    send(8'd1, 8'd5, 1'b0);
    res_ready = 1'b0;
    send(8'd2, 8'd6, 1'b0);
    send(8'd3, 8'd7, 1'b0);
    send(8'd4, 8'd8, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("bp_res_valid", res_valid, 1);
      check("bp_res_data", res_data, 70);
      check("bp_in_ready", in_ready, 0);
      check("bp_busy", busy, 1);
      if (i < 2) tick();
    end
    res_ready = 1'b1;
    #1;
    check("bp_release_still_held", res_valid, 1);
    check("bp_release_no_clear_yet", mac_clear, 0);
    tick();
    check("bp_after_release_valid", res_valid, 0);
    check("bp_after_release_clear", mac_clear, 1);
    check("bp_after_release_busy", busy, 0);

    // Bubbles: in_valid pattern 1,0,0,1,0,1; garbage operands on bubbles.
    tick();
    check("bubble_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      in_valid = vs[i];
      in_x     = 8'(xs[i]);
      in_w     = 8'd2;
      in_last  = (i == 5);
      #1;
      check("bubble_mac_enable", mac_enable, vs[i]);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    check("bubble_res_data", res_data, 120);
    check("bubble_res_count", res_count, 3);

    // Reset after 2 of 4 elements discards the vector.
    send(8'd7, 8'd7, 1'b0);
    send(8'd7, 8'd7, 1'b0);
    reset = 1'b1;
    tick();
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_res_data", res_data, 0);
    check("mid_rst_res_count", res_count, 0);
    check("mid_rst_busy", busy, 0);
    reset = 1'b0;
    #1;
    check("post_rst_mac_clear", mac_clear, 1);
    tick();
    check("post_rst_clear_done", mac_clear, 0);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_no_result", res_valid, 0);
    send(8'd1, 8'd1, 1'b0);
    send(8'd1, 8'd1, 1'b1);
    tick();
    check("fresh_res_valid", res_valid, 1);
    check("fresh_res_data", res_data, 2);
    check("fresh_res_count", res_count, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
